// File: rtl/ov7670_capture_if.sv
// Bundle of the OV7670 camera pins and frame-buffer write and status signals.
// The master modport is the environment: it drives the camera pins and observes
// the write port. The slave modport is the capture block.
interface ov7670_capture_if #(
  parameter int ADDR_W = 19
);
  logic              vsync;
  logic              href;
  logic [7:0]        d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [11:0]       wdata;
  logic              frame_active;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output vsync, href, d,
    input  we, waddr, wdata, frame_active, frame_done, frame_err
  );

  modport slave (
    input  vsync, href, d,
    output we, waddr, wdata, frame_active, frame_done, frame_err
  );
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 pixel capture: turns RGB565 byte pairs into RGB444 frame-buffer writes
// with linear addresses, and reports per-frame status.
// The whole block runs on the camera pixel clock.
// Optional macro OV7670_CAPTURE_DECIMATE_EN stores only even pixels of even lines,
// giving a half-size frame in each axis.
module ov7670_capture #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic pclk,
  input  logic reset,
  ov7670_capture_if.slave bus
);

  // x and line can go past the nominal size, so that too-long lines and frames
  // remain distinguishable from exact ones. They saturate at their all-ones value.
  localparam int XW = $clog2(H_RES + 2);
  localparam int LW = $clog2(V_RES + 2);

`ifdef OV7670_CAPTURE_DECIMATE_EN
  localparam int STRIDE = H_RES / 2;
`else
  localparam int STRIDE = H_RES;
`endif

  localparam logic [XW-1:0]     X_LIM    = XW'(H_RES);
  localparam logic [XW-1:0]     X_MAX    = '1;
  localparam logic [LW-1:0]     L_LIM    = LW'(V_RES);
  localparam logic [LW-1:0]     L_MAX    = '1;
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  typedef enum logic {SYNC, CAPTURE} state_t;

  state_t            state_reg, state_next;
  logic              vsync_d_reg, vsync_d_next;
  logic              href_d_reg, href_d_next;
  logic              phase_reg, phase_next;
  logic [6:0]        hi_reg, hi_next;          // {hi[7:4], hi[2:0]}; hi[3] is never used
  logic [XW-1:0]     x_reg, x_next;
  logic [LW-1:0]     line_reg, line_next;
  logic [ADDR_W-1:0] line_base_reg, line_base_next;
  logic              err_reg, err_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [11:0]       wdata_reg, wdata_next;
  logic              frame_active_reg, frame_active_next;
  logic              frame_done_reg, frame_done_next;
  logic              frame_err_reg, frame_err_next;

  // href is only meaningful outside vertical blanking. Masking it with vsync
  // also makes a vsync rise with href high look like an href falling edge in
  // the same cycle, which gives the line-then-frame ordering for free.
  logic              href_v;
  logic              href_fall;
  logic              vsync_rise;
  logic              vsync_fall;
  logic [11:0]       pixel;
  logic              in_frame;
  logic              keep_pixel;
  logic              advance_base;
  logic [ADDR_W-1:0] x_off;

  assign href_v     = bus.href & ~bus.vsync;
  assign href_fall  = href_d_reg & ~href_v;
  assign vsync_rise = ~vsync_d_reg & bus.vsync;
  assign vsync_fall = vsync_d_reg & ~bus.vsync;
  assign pixel      = {hi_reg[6:3], hi_reg[2:0], bus.d[7], bus.d[4:1]};
  assign in_frame   = (x_reg < X_LIM) && (line_reg < L_LIM);

`ifdef OV7670_CAPTURE_DECIMATE_EN
  assign keep_pixel   = in_frame && !x_reg[0] && !line_reg[0];
  assign advance_base = (line_reg < L_LIM) && line_reg[0];
  assign x_off        = ADDR_W'(x_reg >> 1);
`else
  assign keep_pixel   = in_frame;
  assign advance_base = (line_reg < L_LIM);
  assign x_off        = ADDR_W'(x_reg);
`endif

  // Next-state and output logic for the sync/capture state machine.
  always_comb begin
    state_next        = state_reg;
    vsync_d_next      = bus.vsync;
    href_d_next       = href_v;
    phase_next        = phase_reg;
    hi_next           = hi_reg;
    x_next            = x_reg;
    line_next         = line_reg;
    line_base_next    = line_base_reg;
    err_next          = err_reg;
    we_next           = 1'b0;
    waddr_next        = waddr_reg;
    wdata_next        = wdata_reg;
    frame_active_next = frame_active_reg;
    frame_done_next   = 1'b0;
    frame_err_next    = frame_err_reg;

    case (state_reg)
      SYNC: begin
        if (vsync_fall) begin
          state_next        = CAPTURE;
          phase_next        = 1'b0;
          x_next            = '0;
          line_next         = '0;
          line_base_next    = '0;
          err_next          = 1'b0;
          frame_active_next = 1'b1;
        end
      end

      CAPTURE: begin
        if (href_v) begin
          if (!phase_reg) begin
            hi_next    = {bus.d[7:4], bus.d[2:0]};
            phase_next = 1'b1;
          end else begin
            phase_next = 1'b0;
            if (keep_pixel) begin
              we_next    = 1'b1;
              wdata_next = pixel;
              waddr_next = line_base_reg + x_off;
            end
            x_next = (x_reg == X_MAX) ? x_reg : x_reg + 1'b1;
          end
        end else if (href_fall) begin
          // End of line: drop any unpaired byte and check the line length.
          phase_next = 1'b0;
          if (x_reg != X_LIM) begin
            err_next = 1'b1;
          end
          if (advance_base) begin
            line_base_next = line_base_reg + STRIDE_A;
          end
          line_next = (line_reg == L_MAX) ? line_reg : line_reg + 1'b1;
          x_next    = '0;
        end

        // End of frame sees the line count already updated by a coincident href fall.
        if (vsync_rise) begin
          frame_done_next   = 1'b1;
          frame_err_next    = err_next | (line_next != L_LIM);
          frame_active_next = 1'b0;
          err_next          = 1'b0;
          state_next        = SYNC;
        end
      end

      default: state_next = SYNC;
    endcase
  end

  // State register with synchronous reset; reset abandons any frame in progress.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_reg        <= SYNC;
      vsync_d_reg      <= 1'b0;
      href_d_reg       <= 1'b0;
      phase_reg        <= 1'b0;
      hi_reg           <= '0;
      x_reg            <= '0;
      line_reg         <= '0;
      line_base_reg    <= '0;
      err_reg          <= 1'b0;
      we_reg           <= 1'b0;
      waddr_reg        <= '0;
      wdata_reg        <= '0;
      frame_active_reg <= 1'b0;
      frame_done_reg   <= 1'b0;
      frame_err_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      vsync_d_reg      <= vsync_d_next;
      href_d_reg       <= href_d_next;
      phase_reg        <= phase_next;
      hi_reg           <= hi_next;
      x_reg            <= x_next;
      line_reg         <= line_next;
      line_base_reg    <= line_base_next;
      err_reg          <= err_next;
      we_reg           <= we_next;
      waddr_reg        <= waddr_next;
      wdata_reg        <= wdata_next;
      frame_active_reg <= frame_active_next;
      frame_done_reg   <= frame_done_next;
      frame_err_reg    <= frame_err_next;
    end
  end

  assign bus.we           = we_reg;
  assign bus.waddr        = waddr_reg;
  assign bus.wdata        = wdata_reg;
  assign bus.frame_active = frame_active_reg;
  assign bus.frame_done   = frame_done_reg;
  assign bus.frame_err    = frame_err_reg;

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture. Expected writes are pushed to a queue
// as pixels are driven and popped when the DUT raises we.
module tb_ov7670_capture;
  localparam int H_RES  = 4;
`ifdef OV7670_CAPTURE_DECIMATE_EN
  localparam int V_RES  = 4;
  localparam bit DEC    = 1'b1;
`else
  localparam int V_RES  = 2;
  localparam bit DEC    = 1'b0;
`endif
  localparam int ADDR_W = 19;

  logic pclk  = 1'b0;
  logic reset = 1'b1;
  always #5 pclk = ~pclk;

  ov7670_capture_if #(.ADDR_W(ADDR_W)) bus ();

  ov7670_capture #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W)
  ) dut (
    .pclk (pclk),
    .reset(reset),
    .bus  (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  int m_x, m_line;
  bit m_err;
  logic [ADDR_W+11:0] exp_q[$];

  // Scoreboard side: every write the DUT makes must match the oldest expected one.
  always @(negedge pclk) begin
    if (bus.frame_done === 1'b1) done_cnt++;
    if (bus.we === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", bus.waddr, bus.wdata);
      end else begin
        logic [ADDR_W+11:0] e;
        e = exp_q.pop_front();
        if ({bus.waddr, bus.wdata} !== e) begin
          mismatched++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus.waddr, bus.wdata, e[ADDR_W+11:12], e[11:0]);
        end else begin
          $display("write addr=%0d data=%h", bus.waddr, bus.wdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic h, input logic [7:0] b);
    bus.vsync = v;
    bus.href  = h;
    bus.d     = b;
    tick();
  endtask

  task automatic begin_frame();
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    m_x = 0; m_line = 0; m_err = 1'b0;
  endtask

  // Two bytes of one pixel; the model decides whether and where it is stored.
  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo);
    bit keep;
    int addr;
    drive(1'b0, 1'b1, hi);
    drive(1'b0, 1'b1, lo);
    keep = (m_x < H_RES) && (m_line < V_RES);
    if (DEC) keep = keep && (m_x % 2 == 0) && (m_line % 2 == 0);
    addr = DEC ? (m_line / 2) * (H_RES / 2) + m_x / 2 : m_line * H_RES + m_x;
    if (keep) exp_q.push_back({ADDR_W'(addr), hi[7:4], hi[2:0], lo[7], lo[4:1]});
    m_x++;
  endtask

  task automatic send_random_line(input int npix);
    for (int p = 0; p < npix; p++) begin
      logic [7:0] hi, lo;
      hi = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      send_pixel(hi, lo);
    end
  endtask

  task automatic model_line_end();
    if (m_x != H_RES) m_err = 1'b1;
    m_line++;
    m_x = 0;
  endtask

  task automatic end_line();
    drive(1'b0, 1'b0, 8'h00);
    model_line_end();
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic end_frame();
    drive(1'b1, 1'b0, 8'h00);
    if (m_line != V_RES) m_err = 1'b1;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    bus.vsync = 1'b0; bus.href = 1'b0; bus.d = 8'h00;
    reset = 1'b1;
    repeat (3) tick();
    compared++;
    if ({bus.we, bus.frame_active, bus.frame_done, bus.frame_err} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_flags: got we/act/done/err=%b, required 0000",
               {bus.we, bus.frame_active, bus.frame_done, bus.frame_err});
    end
    compared++;
    if (bus.waddr !== '0 || bus.wdata !== 12'h000) begin
      mismatched++;
      $display("FAIL reset_bus: got waddr=%0d wdata=%h, required 0 000", bus.waddr, bus.wdata);
    end
    reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic_frame();
    int d0;
    d0 = done_cnt;
    begin_frame();
    compared++;
    if (bus.frame_active !== 1'b1) begin
      mismatched++;
      $display("FAIL basic_active: got %b, required 1", bus.frame_active);
    end
    for (int l = 0; l < V_RES; l++) begin
      for (int p = 0; p < H_RES; p++) send_pixel(8'hF8, 8'h1F);
      end_line();
    end
    end_frame();
    compared++;
    if (done_cnt - d0 !== 1) begin
      mismatched++;
      $display("FAIL basic_done: got %0d pulses, required 1", done_cnt - d0);
    end
    compared++;
    if (bus.frame_err !== m_err) begin
      mismatched++;
      $display("FAIL basic_err: got %b, required %b", bus.frame_err, m_err);
    end
    compared++;
    if (bus.frame_active !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_inactive: got %b, required 0", bus.frame_active);
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL basic_missing: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("test_basic_frame done err=%b", m_err);
  endtask

  task automatic test_odd_byte();
    begin_frame();
    send_random_line(H_RES);
    drive(1'b0, 1'b1, 8'hA5);   // unpaired trailing byte
    end_line();
    end_frame();
    compared++;
    if (bus.frame_err !== m_err || m_err !== 1'b1) begin
      mismatched++;
      $display("FAIL odd_err: got %b, required %b", bus.frame_err, m_err);
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL odd_missing: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("test_odd_byte done err=%b", m_err);
  endtask

  task automatic test_short_line();
    begin_frame();
    for (int l = 0; l < V_RES; l++) begin
      send_random_line((l == V_RES - 1) ? H_RES - 1 : H_RES);
      end_line();
    end
    end_frame();
    compared++;
    if (bus.frame_err !== m_err) begin
      mismatched++;
      $display("FAIL short_err: got %b, required %b", bus.frame_err, m_err);
    end
    $display("test_short_line done err=%b", m_err);
  endtask

  task automatic test_extra_line();
    begin_frame();
    for (int l = 0; l < V_RES + 1; l++) begin
      send_random_line(H_RES + ((l == 0) ? 1 : 0));
      end_line();
    end
    end_frame();
    compared++;
    if (bus.frame_err !== m_err) begin
      mismatched++;
      $display("FAIL extra_err: got %b, required %b", bus.frame_err, m_err);
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL extra_missing: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("test_extra_line done err=%b", m_err);
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    d0 = done_cnt;
    begin_frame();
    send_random_line(2);
    bus.href = 1'b1; bus.d = 8'h3C;
    reset = 1'b1;
    tick();
    compared++;
    if ({bus.we, bus.frame_active, bus.frame_done, bus.frame_err} !== 4'b0000) begin
      mismatched++;
      $display("FAIL midreset_flags: got we/act/done/err=%b, required 0000",
               {bus.we, bus.frame_active, bus.frame_done, bus.frame_err});
    end
    tick();
    reset = 1'b0;
    // Remainder of the abandoned frame: vsync stays low, so nothing is captured.
    for (int i = 0; i < 2 * H_RES; i++) drive(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    drive(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2 * H_RES; i++) drive(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    compared++;
    if (done_cnt - d0 !== 0) begin
      mismatched++;
      $display("FAIL midreset_done: got %0d pulses, required 0", done_cnt - d0);
    end
    begin_frame();
    for (int l = 0; l < V_RES; l++) begin
      send_random_line(H_RES);
      end_line();
    end
    end_frame();
    compared++;
    if (done_cnt - d0 !== 1 || bus.frame_err !== m_err) begin
      mismatched++;
      $display("FAIL midreset_next: got pulses=%0d err=%b, required 1 %b", done_cnt - d0, bus.frame_err, m_err);
    end
    $display("test_reset_mid_frame done");
  endtask

  // Frames back to back, each ended by vsync rising while href is still high.
  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    for (int f = 0; f < 2; f++) begin
      begin_frame();
      for (int l = 0; l < V_RES; l++) begin
        send_random_line(H_RES);
        if (l < V_RES - 1) end_line();
      end
      drive(1'b1, 1'b1, 8'h00);
      model_line_end();
      if (m_line != V_RES) m_err = 1'b1;
      drive(1'b1, 1'b0, 8'h00);
      compared++;
      if (bus.frame_err !== m_err) begin
        mismatched++;
        $display("FAIL b2b_err: frame %0d got %b, required %b", f, bus.frame_err, m_err);
      end
    end
    compared++;
    if (done_cnt - d0 !== 2) begin
      mismatched++;
      $display("FAIL b2b_done: got %0d pulses, required 2", done_cnt - d0);
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL b2b_missing: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    bus.vsync = 1'b0;
    bus.href  = 1'b0;
    bus.d     = 8'h00;
    test_reset();
    test_basic_frame();
    test_odd_byte();
    test_short_line();
    test_extra_line();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
